// File: rtl/router_pm_window_counter.sv
// Windowed router performance monitor: per-event counters and per-port occupancy
// accumulators, snapshotted into shadow registers at each window close.
module router_pm_window_counter_cell #(
    parameter int W    = 32,
    parameter int IN_W = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr_i,
    input  logic            close_i,
    input  logic [IN_W-1:0] inc_i,
    output logic [W-1:0]    shadow_o,
    output logic            shadow_sat_o
);
    logic [W-1:0] live_q, live_d, shadow_q, shadow_d, nxt;
    logic         live_sat_q, live_sat_d, shadow_sat_q, shadow_sat_d;
    logic [W:0]   sum;
    logic         ovf;

    always_comb begin
        sum          = {1'b0, live_q} + (W+1)'(inc_i);
        ovf          = sum[W];
        nxt          = ovf ? '1 : sum[W-1:0];
        live_d       = nxt;
        live_sat_d   = live_sat_q | ovf;
        shadow_d     = shadow_q;
        shadow_sat_d = shadow_sat_q;
        if (clr_i) begin
            live_d       = '0;
            live_sat_d   = 1'b0;
            shadow_d     = '0;
            shadow_sat_d = 1'b0;
        end else if (close_i) begin
            // the boundary-cycle increment belongs to the closing window
            shadow_d     = nxt;
            shadow_sat_d = live_sat_q | ovf;
            live_d       = '0;
            live_sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_q       <= '0;
            live_sat_q   <= 1'b0;
            shadow_q     <= '0;
            shadow_sat_q <= 1'b0;
        end else begin
            live_q       <= live_d;
            live_sat_q   <= live_sat_d;
            shadow_q     <= shadow_d;
            shadow_sat_q <= shadow_sat_d;
        end
    end

    assign shadow_o     = shadow_q;
    assign shadow_sat_o = shadow_sat_q;
endmodule

module router_pm_window_counter #(
    parameter int EVT_NUM  = 10,
    parameter int OCC_NUM  = 8,
    parameter int OCC_IN_W = 2,
    parameter int CNT_W    = 32,
    parameter int ACC_W    = 40,
    parameter int WIN_W    = 16,
    parameter int IDX_W    = $clog2(EVT_NUM + OCC_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [EVT_NUM-1:0]           evt_i,
    input  logic [OCC_NUM*OCC_IN_W-1:0]  occ_i,
    input  logic                         cfg_en_i,
    input  logic                         cfg_clr_i,
    input  logic [WIN_W-1:0]             cfg_win_len_i,
    input  logic                         cfg_snap_i,
    input  logic                         rd_req_i,
    input  logic [IDX_W-1:0]             rd_idx_i,
    output logic                         rd_vld_o,
    output logic [CNT_W-1:0]             rd_data_o,
    output logic                         rd_sat_o,
    output logic                         rd_err_o,
    output logic                         snap_vld_o,
    output logic [CNT_W-1:0]             win_id_o
);
    localparam int N_ENT = EVT_NUM + OCC_NUM;

    logic [EVT_NUM-1:0][CNT_W-1:0] evt_sh;
    logic [EVT_NUM-1:0]            evt_sat;
    logic [OCC_NUM-1:0][ACC_W-1:0] acc_sh;
    logic [OCC_NUM-1:0]            acc_sat, acc_hi;

    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] win_id_q, win_id_d, rd_data_q, rd_data_d;
    logic             snap_vld_q, rd_vld_q, rd_vld_d, rd_sat_q, rd_sat_d, rd_err_q, rd_err_d;
    logic             close;

    // ">=" rather than "==" so shrinking the window below the timer closes promptly
    assign close = !cfg_clr_i && (cfg_snap_i || (cfg_en_i && (cfg_win_len_i != '0) &&
                   (timer_q >= cfg_win_len_i - WIN_W'(1))));

    always_comb begin
        timer_d  = timer_q;
        win_id_d = win_id_q;
        if (cfg_clr_i) begin
            timer_d  = '0;
            win_id_d = '0;
        end else if (close) begin
            timer_d  = '0;
            win_id_d = win_id_q + CNT_W'(1);
        end else if (cfg_en_i) begin
            timer_d  = timer_q + WIN_W'(1);
        end
    end

    for (genvar k = 0; k < EVT_NUM; k++) begin : g_evt
        router_pm_window_counter_cell #(.W(CNT_W), .IN_W(1)) u_cell (
            .clk(clk), .rstn(rstn), .clr_i(cfg_clr_i), .close_i(close),
            .inc_i(evt_i[k] & cfg_en_i),
            .shadow_o(evt_sh[k]), .shadow_sat_o(evt_sat[k])
        );
    end

    for (genvar j = 0; j < OCC_NUM; j++) begin : g_occ
        logic [OCC_IN_W-1:0] occ_inc;
        assign occ_inc   = cfg_en_i ? occ_i[j*OCC_IN_W +: OCC_IN_W] : '0;
        assign acc_hi[j] = (acc_sh[j] >> CNT_W) != '0;
        router_pm_window_counter_cell #(.W(ACC_W), .IN_W(OCC_IN_W)) u_cell (
            .clk(clk), .rstn(rstn), .clr_i(cfg_clr_i), .close_i(close),
            .inc_i(occ_inc),
            .shadow_o(acc_sh[j]), .shadow_sat_o(acc_sat[j])
        );
    end

    // read port sees shadows before this cycle's close lands
    always_comb begin
        rd_vld_d  = rd_req_i;
        rd_data_d = rd_data_q;
        rd_sat_d  = rd_sat_q;
        rd_err_d  = rd_err_q;
        if (rd_req_i) begin
            rd_data_d = '0;
            rd_sat_d  = 1'b0;
            rd_err_d  = 1'b1;
            for (int k = 0; k < EVT_NUM; k++) begin
                if (rd_idx_i == IDX_W'(k)) begin
                    rd_data_d = evt_sh[k];
                    rd_sat_d  = evt_sat[k];
                    rd_err_d  = 1'b0;
                end
            end
            for (int j = 0; j < OCC_NUM; j++) begin
                if (rd_idx_i == IDX_W'(EVT_NUM + j)) begin
                    rd_data_d = acc_hi[j] ? '1 : acc_sh[j][CNT_W-1:0];
                    rd_sat_d  = acc_hi[j] | acc_sat[j];
                    rd_err_d  = 1'b0;
                end
            end
            if (rd_idx_i == IDX_W'(N_ENT)) begin
                rd_data_d = win_id_q;
                rd_err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q    <= '0;
            win_id_q   <= '0;
            snap_vld_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_sat_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            win_id_q   <= win_id_d;
            snap_vld_q <= close;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
            rd_sat_q   <= rd_sat_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_vld_o   = rd_vld_q;
    assign rd_data_o  = rd_data_q;
    assign rd_sat_o   = rd_sat_q;
    assign rd_err_o   = rd_err_q;
    assign snap_vld_o = snap_vld_q;
    assign win_id_o   = win_id_q;
endmodule

// File: doc/router_pm_window_counter.md
Name: router_pm_window_counter

Overview:
- Parametrised successor to the router performance counters.
- Counts EVT_NUM single-bit router events and accumulates OCC_NUM multi-bit occupancy samples (e.g. per-VC credit counts) over programmable sampling windows.
- At each window close, live counters are copied to shadow registers and cleared; shadows are read through a one-cycle read port, so software/testbench sees stable per-window values.
- Sits beside the router core and is fed by SA-local/SA-global valids and outport credit counters.

Parameters:
- EVT_NUM, 10, number of 1-bit event inputs.
- OCC_NUM, 8, number of occupancy inputs.
- OCC_IN_W, 2, width of each occupancy input.
- CNT_W, 32, width of event counters and of rd_data_o.
- ACC_W, 40, width of occupancy accumulators; must satisfy ACC_W >= CNT_W.
- WIN_W, 16, width of window-length config and window timer.
- IDX_W, $clog2(EVT_NUM+OCC_NUM+1), read index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- evt_i  in  EVT_NUM  event strobes; each high cycle counts 1.
- occ_i  in  OCC_NUM x OCC_IN_W  occupancy sampled every RUN cycle.
- cfg_en_i  in  1  1 = RUN, 0 = IDLE (hold).
- cfg_clr_i  in  1  pulse: clear live counters, shadows, sticky bits, timer, window id.
- cfg_win_len_i  in  WIN_W  window length in cycles; 0 = no automatic close.
- cfg_snap_i  in  1  pulse: force a window close.
- rd_req_i  in  1  read request.
- rd_idx_i  in  IDX_W  read index.
- rd_vld_o  out  1  read data valid, one cycle after rd_req_i.
- rd_data_o  out  CNT_W  read data.
- rd_sat_o  out  1  sticky saturation flag of the selected entry.
- rd_err_o  out  1  index out of range.
- snap_vld_o  out  1  one-cycle pulse when a window closes.
- win_id_o  out  CNT_W  number of closed windows, wrapping.

Behaviour:
- Reset (rstn low, asynchronous): all live counters, accumulators, shadows, sticky bits, timer, win_id_o, rd_* outputs and snap_vld_o are 0; state = IDLE.
- State IDLE (cfg_en_i=0):
  - Events and occupancy are ignored; timer holds.
  - cfg_snap_i still closes a window.
  - Reads are served.
- State RUN (cfg_en_i=1):
  - Each cycle, live_evt[k] += evt_i[k] and live_acc[j] += occ_i[j], zero-extended.
  - The timer increments.
  - IDLE->RUN takes effect the cycle cfg_en_i is sampled high; RUN->IDLE the cycle it is sampled low.
- Saturation:
  - A live counter at all-ones stays all-ones and sets its sticky live_sat bit.
  - Event counters saturate at CNT_W ones; accumulators at ACC_W ones.
  - No wrap-around.
- Window close: occurs when (RUN and cfg_win_len_i!=0 and timer==cfg_win_len_i-1) or cfg_snap_i. In that cycle:
  - The shadow receives live value plus that cycle's increment (the boundary-cycle event belongs to the closing window).
  - The shadow sat bit receives live_sat OR the sat caused this cycle.
  - Live counters, live_sat and timer clear to 0.
  - win_id_o increments, wrapping at 2^CNT_W.
  - snap_vld_o is high the following cycle (registered).
- If cfg_win_len_i is changed mid-window and timer >= new length-1, the window closes on the next RUN cycle.
- cfg_clr_i has priority over close and counting. That cycle's events are discarded and no snap_vld_o is generated.
- Reads:
  - rd_req_i is sampled at cycle T; rd_vld_o and data appear at T+1. Back-to-back reads are supported every cycle.
  - Index 0..EVT_NUM-1: event shadow.
  - Index EVT_NUM..EVT_NUM+OCC_NUM-1: accumulator shadow. If any bit above CNT_W is set, rd_data_o = all ones and rd_sat_o = 1; otherwise the low CNT_W bits are returned.
  - Index EVT_NUM+OCC_NUM: win_id_o value, rd_sat_o = 0.
  - Any higher index: rd_data_o = 0, rd_err_o = 1.
  - A read coinciding with a close returns the pre-close shadow.
  - Without a request, rd_vld_o = 0 and rd_data_o/rd_sat_o/rd_err_o hold their last values.
- Reset asserted mid-window or mid-read: all state is lost immediately, with no pending rd_vld_o.

Test Plan:
- Reset, cfg_en_i=1, win_len=100, evt_i[0] constantly high for 250 cycles:
  - snap_vld_o pulses at cycles 100 and 200.
  - Reading index 0 returns 100; index EVT_NUM+OCC_NUM returns 2.
- occ_i[3]=2 every cycle, win_len=10 -> read index EVT_NUM+3 after the first close returns 20, rd_sat_o=0.
- CNT_W=4, win_len=0, evt_i[1] high 20 cycles, then cfg_snap_i -> read index 1 returns 15 with rd_sat_o=1. The next window's read returns sat=0 once live is cleared.
- evt_i[2] high only in the closing cycle of a win_len=5 window -> closing shadow = 1, next window shadow = 0.
- cfg_clr_i in the same cycle as a scheduled close -> no snap_vld_o; all reads return 0; win_id = 0.
- Read index EVT_NUM+OCC_NUM+1 -> rd_err_o=1, rd_data_o=0. Toggle cfg_en_i=0 for 7 cycles within a 10-cycle window -> the close is delayed by exactly 7 cycles. Assert rstn mid-window -> all outputs 0 asynchronously.
